// File: rtl/snn_uart_loader.sv
// UART-to-SNN front end: unpacks a streamed image into the 1-bit input RAM,
// runs snn_core, then reports the digit over UART and on the LEDs.
module snn_uart_loader #(
    parameter int IMG_BITS = 784,
    parameter int ADDR_W   = 10,
    parameter bit TX_ASCII = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    input  logic              tx_rdy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_data,
    output logic              snn_start,
    input  logic              snn_done,
    input  logic [3:0]        snn_digit,
    output logic [7:0]        led
);

    localparam int NBYTES = (IMG_BITS + 7) / 8;
    localparam int LAST   = IMG_BITS - 8 * (NBYTES - 1);

    // First pixel of the final (possibly short) byte, and the very last pixel.
    localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'(IMG_BITS - LAST);
    localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(IMG_BITS - 1);
    localparam logic [2:0]        LAST_CNT  = 3'(LAST - 1);

    typedef enum logic [2:0] {
        RX_WAIT,
        UNPACK,
        START,
        WAIT_DONE,
        SEND
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pix;
    logic [7:0]        sh;
    logic [2:0]        bits_left;
    logic [3:0]        last_digit;
    logic              overrun;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_nx  = state;
        ram_we    = 1'b0;
        snn_start = 1'b0;
        tx_start  = 1'b0;
        case (state)
            RX_WAIT: begin
                if (rx_rdy) state_nx = UNPACK;
            end
            UNPACK: begin
                ram_we = 1'b1;
                if (bits_left == 3'd0) state_nx = (pix == LAST_PIX) ? START : RX_WAIT;
            end
            START: begin
                snn_start = 1'b1;
                state_nx  = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (snn_done) state_nx = SEND;
            end
            SEND: begin
                if (tx_rdy) begin
                    tx_start = 1'b1;
                    state_nx = RX_WAIT;
                end
            end
            default: state_nx = RX_WAIT;
        endcase
    end

    // Address and data come straight from reset registers, so they never go X.
    assign ram_addr = pix;
    assign ram_data = sh[0];
    assign led      = {overrun, (state != RX_WAIT), 2'b00, last_digit};

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            state      <= RX_WAIT;
            pix        <= '0;
            sh         <= '0;
            bits_left  <= '0;
            last_digit <= '0;
            tx_data    <= '0;
            overrun    <= 1'b0;
        end else begin
            state <= state_nx;
            if (rx_rdy && (state != RX_WAIT)) overrun <= 1'b1;
            case (state)
                RX_WAIT: begin
                    if (rx_rdy) begin
                        sh        <= rx_data;
                        bits_left <= (pix == LAST_BASE) ? LAST_CNT : 3'd7;
                    end
                end
                UNPACK: begin
                    sh        <= {1'b0, sh[7:1]};
                    pix       <= pix + ADDR_W'(1);
                    bits_left <= bits_left - 3'd1;
                end
                START: begin
                    pix <= '0;
                end
                WAIT_DONE: begin
                    if (snn_done) begin
                        last_digit <= snn_digit;
                        tx_data    <= TX_ASCII ? (8'h30 + {4'h0, snn_digit}) : {4'h0, snn_digit};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/snn_uart_loader.md
# snn_uart_loader

Parametrised UART-to-SNN front end. It replaces the plain UART loopback at the top level with a full inference loop:
- unpacks an image streamed byte-by-byte from the UART receiver into the 1-bit-wide input RAM;
- launches `snn_core`;
- waits for the classification;
- returns the digit over the UART transmitter and shows it on the LEDs.

It sits between `uart_rx`/`uart_tx`, `ram_input_unit` and `snn_core` inside the top level.

## Interface
- `IMG_BITS`, 784: image pixels, one bit each, one RAM word per pixel.
- `ADDR_W`, 10: RAM address width; must satisfy 2^ADDR_W ≥ IMG_BITS.
- `TX_ASCII`, 1: 1 = transmit `8'h30 + digit`; 0 = transmit `{4'h0, digit}`.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_rdy`  in  1  one-cycle pulse; `rx_data` valid.
- `rx_data`  in  8  received byte.
- `tx_rdy`  in  1  transmitter idle.
- `tx_start`  out  1  one-cycle transmit request.
- `tx_data`  out  8  byte to transmit; held stable from the `tx_start` cycle until the next result.
- `ram_we`  out  1  input RAM write enable.
- `ram_addr`  out  ADDR_W  input RAM address.
- `ram_data`  out  1  input RAM write data.
- `snn_start`  out  1  one-cycle pulse to `snn_core`.
- `snn_done`  in  1  core finished; `snn_digit` valid in the same cycle.
- `snn_digit`  in  4  classification, 0–9.
- `led`  out  8  `{overrun, busy, 2'b00, last_digit[3:0]}`.

## Operation
- Bytes per image: NBYTES = ceil(IMG_BITS/8). The last byte carries LAST = IMG_BITS − 8·(NBYTES−1) valid bits; the remaining upper bits are ignored.
- Bit order: LSB first. Pixel p maps to byte p/8, bit p%8, RAM address p.
- Internal state: pixel counter `pix` (ADDR_W bits) and byte shift register `sh`.
- FSM states and transitions:
  - RX_WAIT: on `rx_rdy`, load `sh` ← `rx_data`, compute bits-this-byte (8, or LAST on the final byte), go to UNPACK.
  - UNPACK: each cycle drive `ram_we`=1, `ram_addr`=`pix`, `ram_data`=`sh[0]`; then shift `sh` right and increment `pix`. After the byte's final bit:
    - go to START if `pix` reached IMG_BITS;
    - otherwise return to RX_WAIT.
  - START: `snn_start`=1 for one cycle, clear `pix`, go to WAIT_DONE.
  - WAIT_DONE: on `snn_done`, latch `snn_digit` into `last_digit`, form `tx_data`, go to SEND.
  - SEND: in the first cycle with `tx_rdy`=1, pulse `tx_start`, go to RX_WAIT.
- `busy` = state ≠ RX_WAIT.
- Overrun:
  - An `rx_rdy` arriving in UNPACK, START, WAIT_DONE or SEND is discarded: no RAM write, no counter change.
  - It sets the sticky `overrun` flag, which is cleared only by `rst`.
- `snn_done` arriving outside WAIT_DONE is ignored.
- `ram_we` is 0 in every state except UNPACK. `ram_addr` and `ram_data` are don't-care when `ram_we`=0 but must not toggle X.

## Timing
- Reset: state RX_WAIT, `pix`=0, and all of the following are 0: `tx_start`, `tx_data`, `ram_we`, `ram_addr`, `ram_data`, `snn_start`, `led`.
- `rx_rdy` at cycle t → RAM writes at t+1 … t+k, where k = 8 or LAST.
- Next byte accepted from cycle t+k+1. UART byte spacing far exceeds 9 cycles, so overrun means a protocol violation, not normal traffic.
- Final write at cycle f → `snn_start` high at f+1 only.
- `snn_done` at cycle d → `led[3:0]` and `tx_data` valid at d+1. `tx_start` fires at the first cycle c ≥ d+1 with `tx_rdy`=1.
- `rst` asserted mid-operation (any state) → all outputs return to reset values next cycle; a partially loaded image is abandoned, and the next byte is written starting at address 0.

## Test plan
- Defaults; stream 98 × `8'hFF` → exactly 784 writes, addresses 0..783, all `ram_data`=1; a single `snn_start` one cycle after the write to address 783.
- First byte `8'hA5` → addresses 0..7 written 1,0,1,0,0,1,0,1.
- Full image, then `snn_done` with `snn_digit`=7, `TX_ASCII`=1, `tx_rdy` held low 20 cycles → `tx_start` withheld for those 20 cycles, then pulses once with `tx_data`=`8'h37`; `led`=`8'h07` after return to RX_WAIT.
- Byte sent during WAIT_DONE → no RAM write, `led[7]`=1 and it stays 1 after the result is sent. `TX_ASCII`=0, digit 3 → `tx_data`=`8'h03`.
- `rst` during the 4th bit of the 10th byte → `ram_we`=0 next cycle, `led`=0; the following byte writes addresses 0..7.
- `IMG_BITS`=20 → 3 bytes; the third byte (`8'hFF`) produces 4 writes (addresses 16..19), then `snn_start`.
